fetch_ir_unit: RTL and testbench
================================

# fetch_ir_unit

Holds the architectural program counter, instruction register and memory data register of the 16-bit multicycle core. It sits between unified memory and the multicycle `controller`. It selects the memory address, captures fetched instructions and load data, and advances the PC under the controller's `pcen`/`pcsrc`/`iord`/`irwrite` strobes. It decodes the latched instruction into the `op`/`cz` fields that feed the controller and the register/immediate fields that feed the datapath.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset (word address).
- `clk` in 1: single system clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `pcen` in 1: PC write enable, from the controller.
- `pcsrc` in 2: next-PC select, from the controller.
- `iord` in 1: memory address select; 0 selects PC, 1 selects `aluout`.
- `irwrite` in 1: IR write enable.
- `aluresult` in 16: combinational ALU output.
- `aluout` in 16: registered ALU output.
- `rbdata` in 16: register-file read port B, used for register-indirect jumps.
- `memrdata` in 16: memory read data, valid in the same cycle as `memaddr`.
- `memaddr` out 16: memory address.
- `pc` out 16: current PC.
- `instr` out 16: latched instruction.
- `op` out 4: `instr[15:12]`, to the controller.
- `cz` out 2: `instr[1:0]`, to the controller.
- `ra` out 3, `rb` out 3, `rc` out 3: `instr[11:9]`, `instr[8:6]`, `instr[5:3]`.
- `imm6` out 16: sign-extended `instr[5:0]`.
- `imm9` out 16: sign-extended `instr[8:0]`.
- `mdr` out 16: registered memory data.
- `instret` out 16: count of IR loads, wraps modulo 2^16.

## Operation
- Address mux (combinational):
  - `memaddr` = `iord` ? `aluout` : `pc`.
- Next PC, applied only when `pcen`=1:
  - `pcsrc` 00: `aluresult` (PC+1 at fetch).
  - `pcsrc` 01: `aluout` (branch target computed in an earlier state).
  - `pcsrc` 10: `rbdata`.
  - `pcsrc` 11: reserved; PC holds even when `pcen`=1.
- IR: loads `memrdata` when `irwrite`=1, otherwise holds.
- `instret` increments by 1 on every cycle with `irwrite`=1, wrapping 16'hFFFF -> 0000.
- MDR: loads `memrdata` every non-reset cycle, unconditionally (standard multicycle MDR behaviour).
- Decode fields, imm6 and imm9 are pure combinational slices of `instr`. No decode depends on `memrdata` directly.
- Fixed ISA opcodes that `op` must present unchanged:
  - ADD/ADC 0000
  - NDU/NDZ 0010
  - LW 0100
  - SW 0101
  - BEQ 0110
  - JAL 0111
- Word-addressed memory. PC arithmetic is not performed here; the ALU supplies PC+1 and all targets.

## Timing
- Reset (synchronous, `reset`=1 at a rising edge):
  - `pc`=RESET_PC, `instr`=0 (decodes as ADD r0,r0,r0 with `cz`=00), `mdr`=0, `instret`=0.
  - `reset` has priority over `pcen` and `irwrite` in the same cycle.
- While `reset` is held, outputs stay at their reset values.
- Reset mid-instruction discards the IR contents and any pending PC update. No partial state survives.
- Fetch cycle (`iord`=0, `irwrite`=1, `pcen`=1, `pcsrc`=00) at edge N:
  - IR captures the word at the old PC.
  - PC becomes `aluresult` at that same edge.
  - `memaddr` follows the new PC combinationally after the edge.
- Latency:
  - `memaddr` to `instr`/`mdr`: one edge.
  - `instr` to `op`/`cz`/fields/immediates: zero cycles (combinational).
  - `pcen` to `pc`: one edge.
- Simultaneous `irwrite` and `iord`=1 is legal: IR loads from `aluout`. The controller never issues it, but the block must not special-case it.
- Sign extension:
  - imm6 = {{10{instr[5]}}, instr[5:0]}.
  - imm9 = {{7{instr[8]}}, instr[8:0]}.

## Structure
- Shared package `isa_pkg`:
  - opcode constants (OP_ADD=4'b0000, OP_NDU=4'b0010, OP_LW=4'b0100, OP_SW=4'b0101, OP_BEQ=4'b0110, OP_JAL=4'b0111);
  - `pcsrc` encodings PCSRC_ALU, PCSRC_ALUOUT, PCSRC_RB, PCSRC_HOLD;
  - field bit positions.
  - The controller uses the same package.
- One natural sub-module: `instr_decode`, the combinational field/immediate extractor, reusable by a later pipelined variant.
- Register-with-enable flops stay inline.

## Test plan
- Reset with RESET_PC=16'h0010 -> `pc`=0010, `instr`=0, `op`=0000, `cz`=00, `instret`=0, `memaddr`=0010.
- Fetch with `memrdata`=16'b0000_001_001_000_0_10 (ADC), `aluresult`=0011, `pcen`=`irwrite`=1 -> after edge `op`=0000, `cz`=10, `ra`=1, `rb`=1, `pc`=0011, `instret`=1.
- LW data phase with `iord`=1, `aluout`=0050, `memrdata`=BEEF -> `memaddr`=0050 combinationally, `mdr`=BEEF after one edge, `instr` unchanged.
- Branch and jump selection:
  - `pcsrc`=01, `aluout`=0100 -> `pc`=0100.
  - `pcsrc`=10, `rbdata`=0200 -> `pc`=0200.
  - `pcsrc`=11 with `pcen`=1 -> `pc` holds.
  - `pcen`=0 with any `pcsrc` -> `pc` holds.
- Immediates:
  - IR=0100_010_000_110000 -> `imm6`=FFF0.
  - IR=0111_000_100000000 -> `imm9`=FF00.
- Reset asserted in the same cycle as `pcen`=`irwrite`=1 -> reset values win.
- `instret` preloaded to FFFF via 65535 fetches, then one more fetch -> `instret`=0000.

Source files
------------

// File: rtl/isa_pkg.sv
// ---------------------------------------------------------------------------
// isa_pkg
// Shared ISA definitions for the 16-bit multicycle core. Both the fetch/IR
// unit and the multicycle controller import this package. It holds the
// following:
//   - opcode constants that op must present unchanged
//   - pcsrc encodings for the next-PC mux
//   - bit positions of the instruction fields
//   - sign-extension helpers for the two immediate formats
// ---------------------------------------------------------------------------
package isa_pkg;

    localparam int XLEN = 16;

    // Fixed opcodes (instr[15:12])
    localparam logic [3:0] OP_ADD = 4'b0000;  // ADD/ADC
    localparam logic [3:0] OP_NDU = 4'b0010;  // NDU/NDZ
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b0110;
    localparam logic [3:0] OP_JAL = 4'b0111;

    // Next-PC source select
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,  // combinational ALU result (PC+1 at fetch)
        PCSRC_ALUOUT = 2'b01,  // registered ALU result (branch target)
        PCSRC_RB     = 2'b10,  // register-indirect jump target
        PCSRC_HOLD   = 2'b11   // reserved: PC holds
    } pcsrc_e;

    // Instruction field bit positions
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int RA_MSB   = 11;
    localparam int RA_LSB   = 9;
    localparam int RB_MSB   = 8;
    localparam int RB_LSB   = 6;
    localparam int RC_MSB   = 5;
    localparam int RC_LSB   = 3;
    localparam int CZ_MSB   = 1;
    localparam int CZ_LSB   = 0;
    localparam int IMM6_MSB = 5;
    localparam int IMM9_MSB = 8;

    function automatic logic [XLEN-1:0] sext6(input logic [5:0] v);
        return {{(XLEN-6){v[5]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] sext9(input logic [8:0] v);
        return {{(XLEN-9){v[8]}}, v};
    endfunction

endpackage

// File: rtl/fetch_ir_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_ir_unit_if
// Bundles the signals between the fetch/IR unit, the controller, the
// datapath and unified memory.
//   Inputs to the unit:
//     - controller strobes: pcen, pcsrc, iord, irwrite
//     - datapath values: aluresult, aluout, rbdata
//     - memory read data: memrdata
//   Outputs from the unit:
//     - memory address: memaddr
//     - architectural state: pc, instr, mdr, instret
//     - decoded fields: op, cz, ra, rb, rc, imm6, imm9
// Modports:
//   - slave: the fetch/IR unit.
//   - master: whoever drives the strobes and consumes the state, which is
//     the controller/datapath or a testbench.
// ---------------------------------------------------------------------------
interface fetch_ir_unit_if;
    import isa_pkg::*;

    logic            pcen;
    logic [1:0]      pcsrc;
    logic            iord;
    logic            irwrite;
    logic [XLEN-1:0] aluresult;
    logic [XLEN-1:0] aluout;
    logic [XLEN-1:0] rbdata;
    logic [XLEN-1:0] memrdata;

    logic [XLEN-1:0] memaddr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [3:0]      op;
    logic [1:0]      cz;
    logic [2:0]      ra;
    logic [2:0]      rb;
    logic [2:0]      rc;
    logic [XLEN-1:0] imm6;
    logic [XLEN-1:0] imm9;
    logic [XLEN-1:0] mdr;
    logic [XLEN-1:0] instret;

    modport slave (
        input  pcen, pcsrc, iord, irwrite, aluresult, aluout, rbdata, memrdata,
        output memaddr, pc, instr, op, cz, ra, rb, rc, imm6, imm9, mdr, instret
    );

    modport master (
        output pcen, pcsrc, iord, irwrite, aluresult, aluout, rbdata, memrdata,
        input  memaddr, pc, instr, op, cz, ra, rb, rc, imm6, imm9, mdr, instret
    );

endinterface

// File: rtl/fetch_ir_unit_instr_decode.sv
// ---------------------------------------------------------------------------
// instr_decode
// Purely combinational field/immediate extractor for a 16-bit instruction.
// It is kept separate so that a pipelined variant can reuse it per stage.
//   instr_i : instruction word
//   op_o    : instr[15:12]
//   cz_o    : instr[1:0]
//   ra_o    : instr[11:9]
//   rb_o    : instr[8:6]
//   rc_o    : instr[5:3]
//   imm6_o  : sign-extended instr[5:0]
//   imm9_o  : sign-extended instr[8:0]
// ---------------------------------------------------------------------------
module instr_decode
    import isa_pkg::*;
(
    input  logic [XLEN-1:0] instr_i,
    output logic [3:0]      op_o,
    output logic [1:0]      cz_o,
    output logic [2:0]      ra_o,
    output logic [2:0]      rb_o,
    output logic [2:0]      rc_o,
    output logic [XLEN-1:0] imm6_o,
    output logic [XLEN-1:0] imm9_o
);

    assign op_o   = instr_i[OP_MSB:OP_LSB];
    assign cz_o   = instr_i[CZ_MSB:CZ_LSB];
    assign ra_o   = instr_i[RA_MSB:RA_LSB];
    assign rb_o   = instr_i[RB_MSB:RB_LSB];
    assign rc_o   = instr_i[RC_MSB:RC_LSB];
    assign imm6_o = sext6(instr_i[IMM6_MSB:0]);
    assign imm9_o = sext9(instr_i[IMM9_MSB:0]);

endmodule

// File: rtl/fetch_ir_unit.sv
// ---------------------------------------------------------------------------
// fetch_ir_unit
// Holds the PC, the instruction register, the memory data register and the
// retired-instruction counter of the 16-bit multicycle core. It also drives
// the memory address.
//   clk   : system clock; all state updates on its rising edge
//   reset : synchronous, active-high; takes priority over pcen and irwrite
//   bus   : fetch_ir_unit_if.slave, carrying strobes, datapath values,
//           memory data, state and decoded fields
// RESET_PC : word address loaded into the PC on reset.
// ---------------------------------------------------------------------------
module fetch_ir_unit
    import isa_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ir_unit_if.slave bus
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
    logic [XLEN-1:0] instret_q, instret_d;

    // Next-state logic. pcsrc=11 is reserved and holds the PC even when
    // pcen is set.
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        mdr_d     = bus.memrdata;
        instret_d = instret_q;

        if (bus.pcen) begin
            case (pcsrc_e'(bus.pcsrc))
                PCSRC_ALU:    pc_d = bus.aluresult;
                PCSRC_ALUOUT: pc_d = bus.aluout;
                PCSRC_RB:     pc_d = bus.rbdata;
                default:      pc_d = pc_q;
            endcase
        end

        // The IR loads whatever memory returns, regardless of iord. A load
        // with iord=1 is legal and fetches from aluout.
        if (bus.irwrite) begin
            instr_d   = bus.memrdata;
            instret_d = instret_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            mdr_q     <= '0;
            instret_q <= '0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            mdr_q     <= mdr_d;
            instret_q <= instret_d;
        end
    end

    assign bus.memaddr = bus.iord ? bus.aluout : pc_q;
    assign bus.pc      = pc_q;
    assign bus.instr   = instr_q;
    assign bus.mdr     = mdr_q;
    assign bus.instret = instret_q;

    logic [3:0]      op_w;
    logic [1:0]      cz_w;
    logic [2:0]      ra_w, rb_w, rc_w;
    logic [XLEN-1:0] imm6_w, imm9_w;

    instr_decode u_decode (
        .instr_i (instr_q),
        .op_o    (op_w),
        .cz_o    (cz_w),
        .ra_o    (ra_w),
        .rb_o    (rb_w),
        .rc_o    (rc_w),
        .imm6_o  (imm6_w),
        .imm9_o  (imm9_w)
    );

    assign bus.op   = op_w;
    assign bus.cz   = cz_w;
    assign bus.ra   = ra_w;
    assign bus.rb   = rb_w;
    assign bus.rc   = rc_w;
    assign bus.imm6 = imm6_w;
    assign bus.imm9 = imm9_w;

endmodule

// File: tb/tb_fetch_ir_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_ir_unit
// Scoreboard bench for fetch_ir_unit. Each stimulus pushes the expected
// architectural state, and the state is popped and compared one edge later.
// ---------------------------------------------------------------------------
module tb_fetch_ir_unit;

    localparam logic [15:0] RST_PC = 16'h0010;

    logic clk;
    logic reset;

    fetch_ir_unit_if bus ();

    fetch_ir_unit #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] mdr;
        logic [15:0] instret;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    // Expected-state tracking
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_instret;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.pcen      = 1'b0;
        bus.pcsrc     = 2'b00;
        bus.iord      = 1'b0;
        bus.irwrite   = 1'b0;
        bus.aluresult = 16'h0000;
        bus.aluout    = 16'h0000;
        bus.rbdata    = 16'h0000;
        bus.memrdata  = 16'h0000;
    endtask

    task automatic test_reset();
        exp_t e;
        drive_idle();
        reset = 1'b1;
        step();
        sb_q.push_back('{"reset", RST_PC, 16'h0000, 16'h0000, 16'h0000});
        step();
        e = sb_q.pop_front();
        checks += 7;
        if (bus.pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.name, bus.pc, e.pc); end
        if (bus.instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.name, bus.instr, e.instr); end
        if (bus.mdr !== e.mdr) begin errors++; $display("FAIL %s mdr: got %h expected %h", e.name, bus.mdr, e.mdr); end
        if (bus.instret !== e.instret) begin errors++; $display("FAIL %s instret: got %h expected %h", e.name, bus.instret, e.instret); end
        if (bus.op !== 4'b0000) begin errors++; $display("FAIL %s op: got %b expected 0000", e.name, bus.op); end
        if (bus.cz !== 2'b00) begin errors++; $display("FAIL %s cz: got %b expected 00", e.name, bus.cz); end
        if (bus.memaddr !== RST_PC) begin errors++; $display("FAIL %s memaddr: got %h expected %h", e.name, bus.memaddr, RST_PC); end
        $display("reset: pc=%h instr=%h instret=%h", bus.pc, bus.instr, bus.instret);
        reset     = 1'b0;
        m_pc      = RST_PC;
        m_instr   = 16'h0000;
        m_instret = 16'h0000;
    endtask

    task automatic test_fetch();
        exp_t e;
        drive_idle();
        bus.memrdata  = 16'b0000_001_001_000_0_10;  // ADC r1,r1,r0
        bus.aluresult = 16'h0011;
        bus.pcen      = 1'b1;
        bus.irwrite   = 1'b1;
        bus.pcsrc     = 2'b00;
        #1;
        checks++;
        if (bus.memaddr !== m_pc) begin errors++; $display("FAIL fetch memaddr_pre: got %h expected %h", bus.memaddr, m_pc); end
        m_pc = 16'h0011; m_instr = bus.memrdata; m_instret = m_instret + 16'd1;
        sb_q.push_back('{"fetch", m_pc, m_instr, 16'h0242, m_instret});
        step();
        drive_idle();
        e = sb_q.pop_front();
        checks += 9;
        if (bus.pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.name, bus.pc, e.pc); end
        if (bus.instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.name, bus.instr, e.instr); end
        if (bus.mdr !== e.mdr) begin errors++; $display("FAIL %s mdr: got %h expected %h", e.name, bus.mdr, e.mdr); end
        if (bus.instret !== e.instret) begin errors++; $display("FAIL %s instret: got %h expected %h", e.name, bus.instret, e.instret); end
        if (bus.op !== 4'b0000) begin errors++; $display("FAIL %s op: got %b expected 0000", e.name, bus.op); end
        if (bus.cz !== 2'b10) begin errors++; $display("FAIL %s cz: got %b expected 10", e.name, bus.cz); end
        if (bus.ra !== 3'd1) begin errors++; $display("FAIL %s ra: got %0d expected 1", e.name, bus.ra); end
        if (bus.rb !== 3'd1) begin errors++; $display("FAIL %s rb: got %0d expected 1", e.name, bus.rb); end
        if (bus.memaddr !== 16'h0011) begin errors++; $display("FAIL %s memaddr: got %h expected 0011", e.name, bus.memaddr); end
        $display("fetch: pc=%h instr=%h op=%b cz=%b instret=%h", bus.pc, bus.instr, bus.op, bus.cz, bus.instret);
    endtask

    task automatic test_lw();
        exp_t e;
        drive_idle();
        bus.iord     = 1'b1;
        bus.aluout   = 16'h0050;
        bus.memrdata = 16'hBEEF;
        #1;
        checks++;
        if (bus.memaddr !== 16'h0050) begin errors++; $display("FAIL lw memaddr: got %h expected 0050", bus.memaddr); end
        sb_q.push_back('{"lw", m_pc, m_instr, 16'hBEEF, m_instret});
        step();
        e = sb_q.pop_front();
        checks += 4;
        if (bus.pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.name, bus.pc, e.pc); end
        if (bus.instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.name, bus.instr, e.instr); end
        if (bus.mdr !== e.mdr) begin errors++; $display("FAIL %s mdr: got %h expected %h", e.name, bus.mdr, e.mdr); end
        if (bus.instret !== e.instret) begin errors++; $display("FAIL %s instret: got %h expected %h", e.name, bus.instret, e.instret); end
        $display("lw: memaddr=%h mdr=%h instr=%h", bus.memaddr, bus.mdr, bus.instr);
    endtask

    // IR load with iord=1: the IR takes memory data fetched from aluout.
    task automatic test_ir_from_aluout();
        exp_t e;
        drive_idle();
        bus.iord     = 1'b1;
        bus.irwrite  = 1'b1;
        bus.aluout   = 16'h0077;
        bus.memrdata = 16'h2A5B;
        #1;
        checks++;
        if (bus.memaddr !== 16'h0077) begin errors++; $display("FAIL ir_aluout memaddr: got %h expected 0077", bus.memaddr); end
        m_instr = 16'h2A5B; m_instret = m_instret + 16'd1;
        sb_q.push_back('{"ir_aluout", m_pc, m_instr, 16'h2A5B, m_instret});
        step();
        e = sb_q.pop_front();
        checks += 3;
        if (bus.instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.name, bus.instr, e.instr); end
        if (bus.instret !== e.instret) begin errors++; $display("FAIL %s instret: got %h expected %h", e.name, bus.instret, e.instret); end
        if (bus.op !== 4'b0010) begin errors++; $display("FAIL %s op: got %b expected 0010", e.name, bus.op); end
        $display("ir_aluout: instr=%h op=%b", bus.instr, bus.op);
    endtask

    typedef struct {
        logic        pcen;
        logic [1:0]  pcsrc;
        logic [15:0] exp_pc;
    } pcsel_t;

    task automatic test_pc_select();
        exp_t   e;
        pcsel_t tbl[7];
        tbl[0] = '{1'b1, 2'b01, 16'h0100};
        tbl[1] = '{1'b1, 2'b10, 16'h0200};
        tbl[2] = '{1'b1, 2'b11, 16'h0200};
        tbl[3] = '{1'b0, 2'b00, 16'h0200};
        tbl[4] = '{1'b0, 2'b01, 16'h0200};
        tbl[5] = '{1'b0, 2'b10, 16'h0200};
        tbl[6] = '{1'b1, 2'b00, 16'h0301};
        for (int i = 0; i < 7; i++) begin
            drive_idle();
            bus.pcen      = tbl[i].pcen;
            bus.pcsrc     = tbl[i].pcsrc;
            bus.aluout    = (i == 0) ? 16'h0100 : 16'hDEAD;
            bus.rbdata    = (i == 1) ? 16'h0200 : 16'hCAFE;
            bus.aluresult = (i == 6) ? 16'h0301 : 16'hF00D;
            bus.memrdata  = 16'h1000 + 16'(i);
            m_pc = tbl[i].exp_pc;
            sb_q.push_back('{$sformatf("pcsel%0d", i), m_pc, m_instr, 16'h1000 + 16'(i), m_instret});
            step();
            e = sb_q.pop_front();
            checks += 3;
            if (bus.pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.name, bus.pc, e.pc); end
            if (bus.instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.name, bus.instr, e.instr); end
            if (bus.mdr !== e.mdr) begin errors++; $display("FAIL %s mdr: got %h expected %h", e.name, bus.mdr, e.mdr); end
            $display("%s: pcen=%b pcsrc=%b pc=%h", e.name, tbl[i].pcen, tbl[i].pcsrc, bus.pc);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        logic [3:0]  op;
        logic [2:0]  rc;
        logic [15:0] imm6;
        logic [15:0] imm9;
    } imm_t;

    task automatic test_imm();
        exp_t e;
        imm_t tbl[4];
        tbl[0] = '{16'b0100_010_000_110000, 4'b0100, 3'b110, 16'hFFF0, 16'h0030};
        tbl[1] = '{16'b0111_000_100000000, 4'b0111, 3'b000, 16'h0000, 16'hFF00};
        tbl[2] = '{16'b0101_011_000_011111, 4'b0101, 3'b011, 16'h001F, 16'h001F};
        tbl[3] = '{16'b0110_111_111_100000, 4'b0110, 3'b100, 16'hFFE0, 16'hFFE0};
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            bus.irwrite  = 1'b1;
            bus.memrdata = tbl[i].word;
            m_instr = tbl[i].word; m_instret = m_instret + 16'd1;
            sb_q.push_back('{$sformatf("imm%0d", i), m_pc, m_instr, tbl[i].word, m_instret});
            step();
            e = sb_q.pop_front();
            checks += 5;
            if (bus.instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.name, bus.instr, e.instr); end
            if (bus.op !== tbl[i].op) begin errors++; $display("FAIL %s op: got %b expected %b", e.name, bus.op, tbl[i].op); end
            if (bus.rc !== tbl[i].rc) begin errors++; $display("FAIL %s rc: got %b expected %b", e.name, bus.rc, tbl[i].rc); end
            if (bus.imm6 !== tbl[i].imm6) begin errors++; $display("FAIL %s imm6: got %h expected %h", e.name, bus.imm6, tbl[i].imm6); end
            if (bus.imm9 !== tbl[i].imm9) begin errors++; $display("FAIL %s imm9: got %h expected %h", e.name, bus.imm9, tbl[i].imm9); end
            $display("%s: instr=%h imm6=%h imm9=%h", e.name, bus.instr, bus.imm6, bus.imm9);
        end
    endtask

    task automatic test_reset_priority();
        exp_t e;
        drive_idle();
        reset         = 1'b1;
        bus.pcen      = 1'b1;
        bus.irwrite   = 1'b1;
        bus.aluresult = 16'h1234;
        bus.memrdata  = 16'hABCD;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{$sformatf("rst_prio%0d", i), RST_PC, 16'h0000, 16'h0000, 16'h0000});
            step();
            e = sb_q.pop_front();
            checks += 4;
            if (bus.pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.name, bus.pc, e.pc); end
            if (bus.instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.name, bus.instr, e.instr); end
            if (bus.mdr !== e.mdr) begin errors++; $display("FAIL %s mdr: got %h expected %h", e.name, bus.mdr, e.mdr); end
            if (bus.instret !== e.instret) begin errors++; $display("FAIL %s instret: got %h expected %h", e.name, bus.instret, e.instret); end
            $display("%s: pc=%h instr=%h instret=%h", e.name, bus.pc, bus.instr, bus.instret);
        end
        reset     = 1'b0;
        m_pc      = RST_PC;
        m_instr   = 16'h0000;
        m_instret = 16'h0000;
    endtask

    task automatic test_instret_wrap();
        exp_t e;
        drive_idle();
        bus.irwrite = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus.memrdata = 16'(i);
            step();
        end
        m_instret = 16'hFFFF;
        checks++;
        if (bus.instret !== m_instret) begin errors++; $display("FAIL wrap_pre instret: got %h expected %h", bus.instret, m_instret); end
        $display("wrap_pre: instret=%h", bus.instret);
        bus.memrdata = 16'h4321;
        m_instret = m_instret + 16'd1;
        sb_q.push_back('{"wrap", m_pc, 16'h4321, 16'h4321, m_instret});
        step();
        drive_idle();
        e = sb_q.pop_front();
        checks += 3;
        if (bus.instret !== e.instret) begin errors++; $display("FAIL %s instret: got %h expected %h", e.name, bus.instret, e.instret); end
        if (bus.instr !== e.instr) begin errors++; $display("FAIL %s instr: got %h expected %h", e.name, bus.instr, e.instr); end
        if (bus.pc !== e.pc) begin errors++; $display("FAIL %s pc: got %h expected %h", e.name, bus.pc, e.pc); end
        $display("wrap: instret=%h", bus.instret);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive_idle();
        test_reset();
        test_fetch();
        test_lw();
        test_ir_from_aluout();
        test_pc_select();
        test_imm();
        test_reset_priority();
        test_instret_wrap();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
